// File: rtl/filter_pkg.sv
// Shared definitions for the sample filter datapath: mode encoding,
// saturation and offset-binary conversion used by the engine and DAC callers.
package filter_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_DIFF1 = 2'd1,
    MODE_DIFF2 = 2'd2,
    MODE_AVG   = 2'd3
  } mode_e;

  // Clamp a sign-extended value into the signed range of a w-bit word (w < MAX_W).
  function automatic logic signed [MAX_W-1:0] saturate(
    input  logic signed [MAX_W-1:0] val,
    input  int                      w,
    output logic                    clipped
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic signed [MAX_W-1:0] res;
    hi      = $signed({MAX_W{1'b1}} >> (MAX_W - w + 1));
    lo      = ~hi;
    res     = val;
    clipped = 1'b0;
    if (val > hi) begin
      res     = hi;
      clipped = 1'b1;
    end else if (val < lo) begin
      res     = lo;
      clipped = 1'b1;
    end
    return res;
  endfunction

  // Offset-binary code: invert the sign bit of the w-bit word, keep the top dac_w bits.
  function automatic logic [MAX_W-1:0] to_offset_binary(
    input logic [MAX_W-1:0] y,
    input int               w,
    input int               dac_w
  );
    logic [MAX_W-1:0] code;
    code = (y & ({MAX_W{1'b1}} >> (MAX_W - w))) ^ (MAX_W'(1) << (w - 1));
    return code >> (w - dac_w);
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Shift-register history of accepted samples; tap k (1-based) holds x[n-k]
// at bits [(k-1)*W +: W] of the flattened tap bus.
module sample_delay_line #(
  parameter int W     = 14,
  parameter int DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               shift_en_i,
  input  logic [W-1:0]       data_i,
  output logic [DEPTH*W-1:0] taps_o
);

  logic [DEPTH*W-1:0] taps_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taps_q <= '0;
    end else if (shift_en_i) begin
      taps_q <= {taps_q[(DEPTH-1)*W-1:0], data_i};
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/sample_filter_engine.sv
// Configurable discrete-time filter: pass, first/second difference and moving
// average over a DEPTH-sample window, saturated and registered one cycle after each strobe.
module sample_filter_engine
  import filter_pkg::*;
#(
  parameter int W     = 14,
  parameter int DEPTH = 8,
  parameter int DAC_W = 12
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic [W-1:0]     sample_in,
  input  logic             sample_valid,
  input  logic             hold,
  input  logic [1:0]       mode,
  output logic [W-1:0]     y_out,
  output logic [DAC_W-1:0] dac_code,
  output logic             out_valid,
  output logic             sat
);

  localparam int LG = $clog2(DEPTH);
  localparam int SW = W + LG;

  logic                    accept;
  logic [DEPTH*W-1:0]      taps;
  logic                    unusedTaps;
  logic signed [W-1:0]     xIn;
  logic signed [W-1:0]     x1;
  logic signed [W-1:0]     x2;
  logic signed [W-1:0]     xOld;
  logic signed [SW-1:0]    sum_q;
  logic signed [SW-1:0]    sum_d;
  logic signed [SW-1:0]    avgFull;
  logic signed [W:0]       diff1;
  logic signed [W+1:0]     diff2;
  logic signed [MAX_W-1:0] result;
  mode_e                   modeSel;
  logic signed [W-1:0]     y_d;
  logic signed [W-1:0]     y_q;
  logic [DAC_W-1:0]        dac_d;
  logic [DAC_W-1:0]        dac_q;
  logic                    sat_d;
  logic                    sat_q;
  logic                    valid_q;

  assign accept = sample_valid & ~hold;

  sample_delay_line #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk_i      (CLK_50M),
    .rst_ni     (RST_N),
    .shift_en_i (accept),
    .data_i     (sample_in),
    .taps_o     (taps)
  );

  // Only the first two taps and the oldest one feed the arithmetic; the
  // middle taps exist for reuse by wider filters.
  assign unusedTaps = ^taps;

  assign xIn     = sample_in;
  assign x1      = taps[0 +: W];
  assign x2      = taps[W +: W];
  assign xOld    = taps[(DEPTH-1)*W +: W];
  assign modeSel = mode_e'(mode);

  assign sum_d   = sum_q + SW'(xIn) - SW'(xOld);
  assign avgFull = sum_d >>> LG;
  assign diff1   = (W+1)'(xIn) - (W+1)'(x1);
  assign diff2   = (W+2)'(xIn) - ((W+2)'(x1) <<< 1) + (W+2)'(x2);

  always_comb begin
    result = '0;
    sat_d  = 1'b0;
    case (modeSel)
      MODE_PASS:  result = MAX_W'(xIn);
      MODE_DIFF1: result = MAX_W'(diff1);
      MODE_DIFF2: result = MAX_W'(diff2);
      default:    result = MAX_W'(avgFull);
    endcase
    y_d   = W'(saturate(result, W, sat_d));
    dac_d = DAC_W'(to_offset_binary(MAX_W'(y_d), W, DAC_W));
  end

  // Running sum and results only move on accepted strobes, so outputs hold between them.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      sum_q   <= '0;
      y_q     <= '0;
      dac_q   <= {1'b1, {(DAC_W-1){1'b0}}};
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        sum_q <= sum_d;
        y_q   <= y_d;
        dac_q <= dac_d;
        sat_q <= sat_d;
      end
    end
  end

  assign y_out     = y_q;
  assign dac_code  = dac_q;
  assign sat       = sat_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sample_filter_engine.sv
// Scoreboard bench for sample_filter_engine: a behavioural model queues the
// expected result of each accepted strobe and a negedge monitor checks every cycle.
module tb_sample_filter_engine;

  localparam int W     = 14;
  localparam int DEPTH = 8;
  localparam int DAC_W = 12;

  typedef struct {
    int y;
    int sat;
    int dac;
  } exp_t;

  logic             CLK_50M      = 1'b0;
  logic             RST_N        = 1'b0;
  logic [W-1:0]     sample_in    = '0;
  logic             sample_valid = 1'b0;
  logic             hold         = 1'b0;
  logic [1:0]       mode         = 2'd0;
  logic [W-1:0]     y_out;
  logic [DAC_W-1:0] dac_code;
  logic             out_valid;
  logic             sat;

  exp_t sbQueue[$];
  int   hist[DEPTH];
  int   sumModel   = 0;
  int   checkCount = 0;
  int   passCount  = 0;
  int   lastY      = 0;
  int   lastSat    = 0;
  int   lastDac    = 2048;
  logic expValid   = 1'b0;

  sample_filter_engine #(
    .W     (W),
    .DEPTH (DEPTH),
    .DAC_W (DAC_W)
  ) dut (
    .CLK_50M      (CLK_50M),
    .RST_N        (RST_N),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .hold         (hold),
    .mode         (mode),
    .y_out        (y_out),
    .dac_code     (dac_code),
    .out_valid    (out_valid),
    .sat          (sat)
  );

  always #10 CLK_50M = ~CLK_50M;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic void resetModel();
    for (int i = 0; i < DEPTH; i++) hist[i] = 0;
    sumModel = 0;
  endfunction

  // Reference model: integer arithmetic, floor division via arithmetic shift of an int.
  function automatic void modelAccept(input int x, input int m);
    int   raw;
    exp_t e;
    sumModel = sumModel + x - hist[DEPTH-1];
    case (m)
      0:       raw = x;
      1:       raw = x - hist[0];
      2:       raw = x - 2 * hist[0] + hist[1];
      default: raw = sumModel >>> 3;
    endcase
    e.sat = 0;
    if (raw > 8191) begin
      raw   = 8191;
      e.sat = 1;
    end else if (raw < -8192) begin
      raw   = -8192;
      e.sat = 1;
    end
    e.y   = raw;
    e.dac = (raw + 8192) / 4;
    for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    sbQueue.push_back(e);
  endfunction

  // One call drives one clock cycle of inputs, just after the rising edge.
  task automatic applyStimulus(input int value, input int m, input logic valid, input logic h);
    @(posedge CLK_50M);
    #1;
    sample_in    = W'(value);
    mode         = 2'(m);
    sample_valid = valid;
    hold         = h;
    if (valid && !h && RST_N) modelAccept(value, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b0, 1'b0);
  endtask

  task automatic resetPulse();
    @(posedge CLK_50M);
    #1;
    RST_N        = 1'b0;
    sample_valid = 1'b0;
    hold         = 1'b0;
    resetModel();
    @(posedge CLK_50M);
    #1;
    RST_N = 1'b1;
  endtask

  always @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) expValid <= 1'b0;
    else        expValid <= sample_valid && !hold;
  end

  // Monitor: every falling edge checks valid timing, pops results and confirms outputs hold.
  always @(negedge CLK_50M) begin
    exp_t e;
    if (!RST_N) begin
      checkOutput("rst_y", $signed(y_out), 0);
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_sat", int'(sat), 0);
      checkOutput("rst_dac", int'(dac_code), 2048);
      lastY   = 0;
      lastSat = 0;
      lastDac = 2048;
    end else begin
      checkOutput("out_valid", int'(out_valid), int'(expValid));
      if (out_valid) begin
        checkOutput("sb_nonempty", int'(sbQueue.size() != 0), 1);
        if (sbQueue.size() != 0) begin
          e       = sbQueue.pop_front();
          lastY   = e.y;
          lastSat = e.sat;
          lastDac = e.dac;
        end
      end
      checkOutput("y_out", $signed(y_out), lastY);
      checkOutput("sat", int'(sat), lastSat);
      checkOutput("dac_code", int'(dac_code), lastDac);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetModel();
    for (int i = 0; i < 8; i++)
      applyStimulus(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(posedge CLK_50M);
    #1;
    sample_valid = 1'b0;
    hold         = 1'b0;
    RST_N        = 1'b1;

    $display("[TB] mode 1 ramp and saturation");
    applyStimulus(100, 1, 1'b1, 1'b0);
    idle(1);
    applyStimulus(200, 1, 1'b1, 1'b0);
    idle(1);
    applyStimulus(350, 1, 1'b1, 1'b0);
    idle(1);
    applyStimulus(8191, 1, 1'b1, 1'b0);
    applyStimulus(-8192, 1, 1'b1, 1'b0);
    applyStimulus(0, 1, 1'b1, 1'b0);
    idle(2);

    $display("[TB] mode 2");
    resetPulse();
    applyStimulus(0, 2, 1'b1, 1'b0);
    applyStimulus(0, 2, 1'b1, 1'b0);
    applyStimulus(10, 2, 1'b1, 1'b0);
    applyStimulus(10, 2, 1'b1, 1'b0);
    applyStimulus(10, 2, 1'b1, 1'b0);
    idle(2);

    $display("[TB] mode 3 then switch to mode 1");
    resetPulse();
    for (int i = 0; i < 9; i++) applyStimulus(800, 3, 1'b1, 1'b0);
    applyStimulus(800, 1, 1'b1, 1'b0);
    idle(2);

    $display("[TB] hold and mid-operation reset");
    resetPulse();
    applyStimulus(500, 1, 1'b1, 1'b0);
    applyStimulus(900, 1, 1'b1, 1'b1);
    idle(2);
    applyStimulus(600, 1, 1'b1, 1'b0);
    applyStimulus(700, 0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b1);
    idle(2);
    resetPulse();
    applyStimulus(50, 1, 1'b1, 1'b0);
    idle(2);

    $display("[TB] random back-to-back traffic");
    for (int i = 0; i < 60; i++)
      applyStimulus(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
    idle(3);

    checkOutput("sb_drain", sbQueue.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
